// File: rtl/pong_motion_ctrl.sv
// Per-frame motion controller for the wall/bar/ball pixel generator.
// Ports: clk, reset, refr_tick, btn_up, btn_down, serve in;
//   bar_y_t, ball_x_l, ball_y_t, state, hit_count, miss_count,
//   miss_pulse out. All state moves only on refr_tick edges.
module pong_motion_ctrl #(
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480,
  parameter int WALL_X_R  = 35,
  parameter int BAR_X_L   = 600,
  parameter int BAR_X_R   = 603,
  parameter int BAR_H     = 73,
  parameter int BAR_Y0    = 204,
  parameter int BAR_V     = 4,
  parameter int BALL_SIZE = 9,
  parameter int BALL_X0   = 580,
  parameter int BALL_Y0   = 238,
  parameter int BALL_V    = 2,
  parameter int MISS_HOLD = 60,
  localparam int W =
    $clog2(H_MAX > V_MAX ? H_MAX : V_MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refr_tick,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         serve,
  output logic [W-1:0] bar_y_t,
  output logic [W-1:0] ball_x_l,
  output logic [W-1:0] ball_y_t,
  output logic [1:0]   state,
  output logic [7:0]   hit_count,
  output logic [3:0]   miss_count,
  output logic         miss_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_MISS = 2'b10
  } state_t;

  localparam logic [W-1:0] VM   = W'(V_MAX);
  localparam logic [W-1:0] WXR  = W'(WALL_X_R);
  localparam logic [W-1:0] BXL  = W'(BAR_X_L);
  localparam logic [W-1:0] BXR  = W'(BAR_X_R);
  localparam logic [W-1:0] BH   = W'(BAR_H);
  localparam logic [W-1:0] BY0  = W'(BAR_Y0);
  localparam logic [W-1:0] BV   = W'(BAR_V);
  localparam logic [W-1:0] BS   = W'(BALL_SIZE);
  localparam logic [W-1:0] X0   = W'(BALL_X0);
  localparam logic [W-1:0] Y0   = W'(BALL_Y0);
  localparam logic [W-1:0] VB   = W'(BALL_V);
  localparam logic [5:0]   HOLD = 6'(MISS_HOLD - 1);

  state_t       st_q, st_d;
  logic [W-1:0] bar_q, bar_d;
  logic [W-1:0] bx_q, bx_d;
  logic [W-1:0] by_q, by_d;
  logic         dx_q, dx_d;
  logic         dy_q, dy_d;
  logic [7:0]   hit_q, hit_d;
  logic [3:0]   mc_q, mc_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         pulse_d;

  logic [W-1:0] bx_r, by_b, bar_b;
  logic         bar_hit;

  assign bx_r  = bx_q + BS - W'(1);
  assign by_b  = by_q + BS - W'(1);
  assign bar_b = bar_q + BH - W'(1);

  // overlap test only; the direction qualifier is applied below
  assign bar_hit = (bx_r >= BXL) && (bx_r <= BXR) &&
                   (by_b >= bar_q) && (by_q <= bar_b);

  always_comb begin
    st_d    = st_q;
    bar_d   = bar_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hit_d   = hit_q;
    mc_d    = mc_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    // bar: frozen while the miss is shown
    if (st_q != S_MISS && (btn_up ^ btn_down)) begin
      if (btn_up) begin
        bar_d = (bar_q >= BV) ? bar_q - BV : '0;
      end else begin
        bar_d = (bar_q + BH + BV <= VM) ?
                bar_q + BV : VM - BH;
      end
    end

    unique case (st_q)
      S_IDLE: begin
        bx_d = X0;
        by_d = Y0;
        dx_d = 1'b1;
        dy_d = 1'b1;
        if (serve) st_d = S_PLAY;
      end
      S_PLAY: begin
        if (bx_q > BXR) begin
          st_d    = S_MISS;
          cnt_d   = '0;
          pulse_d = 1'b1;
          mc_d    = (mc_q == 4'hF) ? mc_q : mc_q + 4'd1;
        end else begin
          if (by_q <= VB) dy_d = 1'b0;
          if (by_b >= VM - W'(1) - VB) dy_d = 1'b1;
          if (bx_q <= WXR + VB) dx_d = 1'b0;
          if (!dx_d && bar_hit) begin
            dx_d  = 1'b1;
            hit_d = hit_q + 8'd1;
          end
          bx_d = dx_d ? bx_q - VB : bx_q + VB;
          by_d = dy_d ? by_q - VB : by_q + VB;
        end
      end
      S_MISS: begin
        if (cnt_q == HOLD) begin
          st_d = S_IDLE;
          bx_d = X0;
          by_d = Y0;
          dx_d = 1'b1;
          dy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= S_IDLE;
      bar_q      <= BY0;
      bx_q       <= X0;
      by_q       <= Y0;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      hit_q      <= '0;
      mc_q       <= '0;
      cnt_q      <= '0;
      miss_pulse <= 1'b0;
    end else begin
      miss_pulse <= refr_tick & pulse_d;
      if (refr_tick) begin
        st_q  <= st_d;
        bar_q <= bar_d;
        bx_q  <= bx_d;
        by_q  <= by_d;
        dx_q  <= dx_d;
        dy_q  <= dy_d;
        hit_q <= hit_d;
        mc_q  <= mc_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign state      = st_q;
  assign bar_y_t    = bar_q;
  assign ball_x_l   = bx_q;
  assign ball_y_t   = by_q;
  assign hit_count  = hit_q;
  assign miss_count = mc_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Directed bench for pong_motion_ctrl.
// Hand-computed ball trajectory checked at flip points.
module tb_pong_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       refr_tick;
  logic       btn_up;
  logic       btn_down;
  logic       serve;
  logic [9:0] bar_y_t;
  logic [9:0] ball_x_l;
  logic [9:0] ball_y_t;
  logic [1:0] state;
  logic [7:0] hit_count;
  logic [3:0] miss_count;
  logic       miss_pulse;

  int total  = 0;
  int passed = 0;

  pong_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .refr_tick  (refr_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .serve      (serve),
    .bar_y_t    (bar_y_t),
    .ball_x_l   (ball_x_l),
    .ball_y_t   (ball_y_t),
    .state      (state),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .miss_pulse (miss_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, want %0d",
                tag, obs, exp);
  endtask

  task automatic chk_ball(input string tag,
                          input int x, input int y);
    chk({tag, ".x"}, int'(ball_x_l), x);
    chk({tag, ".y"}, int'(ball_y_t), y);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".bar"}, int'(bar_y_t), 204);
    chk_ball(tag, 580, 238);
    chk({tag, ".hit"}, int'(hit_count), 0);
    chk({tag, ".miss"}, int'(miss_count), 0);
    chk({tag, ".pulse"}, int'(miss_pulse), 0);
  endtask

  task automatic tick();
    @(negedge clk);
    refr_tick = 1'b1;
    @(negedge clk);
    refr_tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    refr_tick = 1'b0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    serve     = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_pulse", int'(miss_pulse), 0);
    end
    chk_rst("idle5");

    btn_up = 1'b1;
    tick_n(3);
    chk("bar_up3", int'(bar_y_t), 192);
    chk_ball("idle_ball", 580, 238);

    btn_up   = 1'b0;
    btn_down = 1'b1;
    tick_n(53);
    chk("bar_dn53", int'(bar_y_t), 404);
    tick();
    chk("bar_dn_clamp", int'(bar_y_t), 407);
    tick_n(6);
    chk("bar_dn_hold", int'(bar_y_t), 407);

    btn_up = 1'b1;
    tick();
    chk("bar_both", int'(bar_y_t), 407);
    btn_up   = 1'b0;
    btn_down = 1'b0;

    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    chk("bar_no_tick", int'(bar_y_t), 407);
    btn_up = 1'b0;

    serve = 1'b1;
    tick();
    serve = 1'b0;
    chk("serve_state", int'(state), 1);
    chk_ball("serve_ball", 580, 238);

    btn_up = 1'b1;
    tick();
    chk_ball("k1", 578, 236);
    chk("k1_bar", int'(bar_y_t), 403);
    tick_n(99);
    chk("k100_bar", int'(bar_y_t), 7);
    chk_ball("k100", 380, 38);
    btn_up = 1'b0;

    tick_n(18);
    chk_ball("top_k118", 344, 2);
    tick();
    chk_ball("top_k119", 342, 4);

    tick_n(153);
    chk_ball("wall_k272", 36, 310);
    tick();
    chk_ball("wall_k273", 38, 312);

    tick_n(79);
    chk_ball("bot_k352", 196, 470);
    tick();
    chk_ball("bot_k353", 198, 468);

    tick_n(197);
    chk_ball("hit_k550", 592, 74);
    chk("hit_k550_cnt", int'(hit_count), 0);
    tick();
    chk_ball("hit_k551", 590, 72);
    chk("hit_k551_cnt", int'(hit_count), 1);

    btn_up = 1'b1;
    tick();
    chk("bar_up_k552", int'(bar_y_t), 3);
    tick();
    chk("bar_up_clamp", int'(bar_y_t), 0);
    tick();
    chk("bar_up_hold", int'(bar_y_t), 0);
    chk_ball("k554", 584, 66);
    btn_up = 1'b0;

    tick_n(32);
    chk_ball("top_k586", 520, 2);
    tick_n(234);
    chk_ball("bot_k820", 52, 470);
    tick_n(8);
    chk_ball("wall_k828", 36, 454);
    tick();
    chk_ball("wall_k829", 38, 452);
    tick_n(225);
    chk_ball("top_k1054", 488, 2);
    tick_n(58);
    chk_ball("edge_k1112", 604, 118);
    chk("edge_state", int'(state), 1);
    chk("edge_pulse", int'(miss_pulse), 0);

    tick();
    chk("miss_state", int'(state), 2);
    chk("miss_pulse_hi", int'(miss_pulse), 1);
    chk("miss_cnt", int'(miss_count), 1);
    chk_ball("miss_ball", 604, 118);
    @(negedge clk);
    chk("miss_pulse_lo", int'(miss_pulse), 0);

    btn_down = 1'b1;
    serve    = 1'b1;
    tick_n(59);
    chk("miss59_state", int'(state), 2);
    chk("miss59_bar", int'(bar_y_t), 0);
    chk_ball("miss59", 604, 118);
    chk("miss59_pulse", int'(miss_pulse), 0);
    btn_down = 1'b0;
    serve    = 1'b0;
    tick();
    chk("miss60_state", int'(state), 0);
    chk_ball("miss60", 580, 238);
    chk("miss60_bar", int'(bar_y_t), 0);
    chk("miss60_hit", int'(hit_count), 1);
    chk("miss60_mc", int'(miss_count), 1);

    serve = 1'b1;
    tick();
    serve = 1'b0;
    tick_n(3);
    chk("p2_state", int'(state), 1);
    chk_ball("p2_k3", 574, 232);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_rst("async_rst");
    tick();
    chk_rst("rst_tick");
    reset = 1'b0;
    tick();
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_bar", int'(bar_y_t), 204);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pong_motion_ctrl.md
# pong_motion_ctrl

Per-frame motion controller for the VGA wall/bar/ball pixel generator. It sequences the game objects. Once per frame, on a refresh tick from the sync block during vertical retrace, it moves the bar from the push-buttons and moves the ball. It also resolves wall, bar, screen-edge and miss events. Its position outputs feed the pixel generator's object comparators, so the positions stay stable for the whole visible region.

## Interface
Parameters:
- H_MAX, 640, visible width in pixels
- V_MAX, 480, visible height in lines
- WALL_X_R, 35, right edge of wall (wall spans x 32..35)
- BAR_X_L, 600, bar left column
- BAR_X_R, 603, bar right column
- BAR_H, 73, bar height in lines
- BAR_Y0, 204, bar top at reset
- BAR_V, 4, bar step in pixels per frame
- BALL_SIZE, 9, ball edge length in pixels
- BALL_X0, 580, ball left at serve
- BALL_Y0, 238, ball top at serve
- BALL_V, 2, ball step per frame on each axis
- MISS_HOLD, 60, frames spent in MISS

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- refr_tick  in  1  one-clk pulse per frame, high at v_count=481, h_count=0
- btn_up  in  1  level, move bar up
- btn_down  in  1  level, move bar down
- serve  in  1  level, launch ball from IDLE
- bar_y_t  out  10  bar top line
- ball_x_l  out  10  ball left column
- ball_y_t  out  10  ball top line
- state  out  2  00 IDLE, 01 PLAY, 10 MISS
- hit_count  out  8  bar hits, wraps at 255
- miss_count  out  4  misses, saturates at 15
- miss_pulse  out  1  one-clk pulse on entering MISS

## Operation
- Derived values: ball_x_r = ball_x_l+BALL_SIZE-1; ball_y_b = ball_y_t+BALL_SIZE-1; bar_y_b = bar_y_t+BAR_H-1.
- All state and outputs update only on a clk edge where refr_tick=1. The only exceptions are miss_pulse and reset.
- Bar, in IDLE and PLAY only; frozen in MISS:
  - btn_up and btn_down both high, or both low: no move.
  - Up: if bar_y_t >= BAR_V, then bar_y_t -= BAR_V; otherwise bar_y_t = 0.
  - Down: if bar_y_t+BAR_H+BAR_V <= V_MAX, then bar_y_t += BAR_V; otherwise bar_y_t = V_MAX-BAR_H (407).
- Direction registers: dx_neg and dy_neg. Both are 1 at reset and on every IDLE entry.
- IDLE:
  - Ball is held at (BALL_X0, BALL_Y0).
  - serve=1 on a tick moves to PLAY. The ball does not move on that tick.
- PLAY, on each tick, evaluated on current positions in this order:
  1. Miss: if ball_x_l > BAR_X_R, go to MISS. miss_count increments (saturating). miss_pulse fires. The ball freezes and steps 2–5 are skipped.
  2. Top: if ball_y_t <= BALL_V, then dy_neg = 0.
  3. Bottom: if ball_y_b >= V_MAX-1-BALL_V, then dy_neg = 1.
  4. Wall: if ball_x_l <= WALL_X_R+BALL_V, then dx_neg = 0.
  5. Bar hit: when all of the following hold, set dx_neg = 1 and increment hit_count:
     - dx_neg = 0
     - BAR_X_L <= ball_x_r <= BAR_X_R
     - ball_y_b >= bar_y_t
     - ball_y_t <= bar_y_b
  - Then the ball moves BALL_V on each axis using the updated directions.
  - Bar and ball updates within one tick both use pre-tick positions.
- MISS:
  - A 6-bit frame counter is cleared on entry and incremented per tick.
  - When it reaches MISS_HOLD-1, the next tick goes to IDLE. On that tick the ball reloads to start and directions reset. The bar is kept.
  - serve is ignored in MISS.
- Arithmetic: 10-bit unsigned. Clamp rules guarantee no underflow or overflow.

## Timing
- Reset values, applied immediately and asynchronously:
  - state=IDLE, bar_y_t=204, ball_x_l=580, ball_y_t=238
  - dx_neg=1, dy_neg=1
  - hit_count=0, miss_count=0, miss_pulse=0, MISS counter=0
- Latency: outputs are registered and reflect tick N's update at the clk edge sampling refr_tick=1. They are stable at least until the next frame's tick.
- miss_pulse is high for exactly one clk, coincident with state becoming MISS.
- Reset mid-PLAY or mid-MISS returns to the reset values at once. No pending update completes.
- A tick arriving while reset is high is ignored.
- Inputs are sampled only at ticks. Button activity between ticks has no effect.

## Test plan
- Reset, then 5 ticks with all inputs low: outputs hold the reset values, state=00, miss_pulse never high.
- IDLE, btn_up held for 3 ticks: bar_y_t = 192, ball unchanged. Then btn_down held for 60 ticks: bar_y_t clamps at 407 and stays. Both buttons held: no change.
- serve tick, then 1 tick: ball=(578,236). Continue: ball_y_t never < 2, flips at 2 to 4. ball_x_l flips at 36 to 38, never < 36.
- Hold btn_up so the bar covers the ball rows when ball_x_r reaches 600: dx flips, hit_count becomes 1, ball_x_l peaks at 592.
- Bar parked at 0, ball at bottom rows: ball_x_l reaches 604, then miss_pulse is high for one clk, miss_count=1, state=10, ball frozen. 60 ticks later: state=00, ball=(580,238), bar unchanged.
- Assert reset mid-PLAY between ticks: all outputs return to reset values within the same clk period, with no refr_tick needed.
